// File: rtl/rename_map_table_pkg.sv
// Shared types and sizing for the register rename map table.
package rename_map_table_pkg;

  localparam int NUM_ISSUE  = 4;
  localparam int NUM_COMMIT = 4;
  localparam int NUM_AREGS  = 32;
  localparam int TAG_W      = 7;

  typedef logic [TAG_W-1:0] Tag;
  typedef logic [TAG_W-2:0] RFTag;
  typedef logic [4:0]       AReg;

  // MSB set marks a tag with no physical register behind it (x0, immediates).
  localparam Tag ZERO_TAG = {1'b1, {(TAG_W-1){1'b0}}};

endpackage

// File: rtl/rename_map_table_if.sv
// Rename and commit bundle between dispatch/ROB/free list and the map table.
interface rename_map_table_if;
  import rename_map_table_pkg::*;

  logic                  IN_mispr;
  logic                  IN_mispredFlush;

  logic [NUM_ISSUE-1:0]  IN_renValid;
  AReg                   IN_renRd  [NUM_ISSUE];
  AReg                   IN_renRs1 [NUM_ISSUE];
  AReg                   IN_renRs2 [NUM_ISSUE];
  RFTag                  IN_freeTags [NUM_ISSUE];
  logic [NUM_ISSUE-1:0]  IN_freeTagsValid;

  logic [NUM_ISSUE-1:0]  OUT_issueValid;
  logic                  OUT_stall;
  logic [NUM_ISSUE-1:0]  OUT_renValid;
  Tag                    OUT_srcTag1 [NUM_ISSUE];
  Tag                    OUT_srcTag2 [NUM_ISSUE];
  Tag                    OUT_dstTag  [NUM_ISSUE];
  Tag                    OUT_prevTag [NUM_ISSUE];

  logic [NUM_COMMIT-1:0] IN_commitValid;
  AReg                   IN_commitRd     [NUM_COMMIT];
  Tag                    IN_commitTagDst [NUM_COMMIT];
  Tag                    OUT_commitPrevTags [NUM_COMMIT];
  logic [NUM_COMMIT-1:0] OUT_commitNewest;

  modport master (
    output IN_mispr, IN_mispredFlush, IN_renValid, IN_renRd, IN_renRs1, IN_renRs2,
           IN_freeTags, IN_freeTagsValid, IN_commitValid, IN_commitRd, IN_commitTagDst,
    input  OUT_issueValid, OUT_stall, OUT_renValid, OUT_srcTag1, OUT_srcTag2,
           OUT_dstTag, OUT_prevTag, OUT_commitPrevTags, OUT_commitNewest
  );

  modport slave (
    input  IN_mispr, IN_mispredFlush, IN_renValid, IN_renRd, IN_renRs1, IN_renRs2,
           IN_freeTags, IN_freeTagsValid, IN_commitValid, IN_commitRd, IN_commitTagDst,
    output OUT_issueValid, OUT_stall, OUT_renValid, OUT_srcTag1, OUT_srcTag2,
           OUT_dstTag, OUT_prevTag, OUT_commitPrevTags, OUT_commitNewest
  );

endinterface

// File: rtl/rename_map_table_lookup.sv
// N-slot map read where each slot sees the youngest older slot's write to the same register.
module map_bypass_lookup
  import rename_map_table_pkg::*;
#(
  parameter int N = 4
) (
  input  Tag         baseMap [NUM_AREGS],
  input  AReg        qReg    [N],
  input  logic [N-1:0] wrEn,
  input  AReg        wrReg   [N],
  input  Tag         wrTag   [N],
  output Tag         result  [N]
);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : gSlot
      Tag hit;
      // Start from the base map (x0 forced), then let later older slots override earlier ones.
      always_comb begin
        hit = (qReg[gi] == '0) ? ZERO_TAG : baseMap[qReg[gi]];
        for (int j = 0; j < gi; j++) begin
          if (wrEn[j] && (wrReg[j] == qReg[gi])) hit = wrTag[j];
        end
      end
      assign result[gi] = hit;
    end
  endgenerate

endmodule

// File: rtl/rename_map_table.sv
// Speculative and committed arch->phys maps with rename, commit, mispredict restore and replay.
module rename_map_table
  import rename_map_table_pkg::*;
(
  input logic clk,
  input logic rst,
  rename_map_table_if.slave bus
);

  Tag specMap [NUM_AREGS];
  Tag comMap  [NUM_AREGS];
  Tag specMapNext [NUM_AREGS];
  Tag comMapNext  [NUM_AREGS];

  AReg renRd  [NUM_ISSUE];
  AReg renRs1 [NUM_ISSUE];
  AReg renRs2 [NUM_ISSUE];
  Tag  renDst [NUM_ISSUE];
  Tag  src1   [NUM_ISSUE];
  Tag  src2   [NUM_ISSUE];
  Tag  prev   [NUM_ISSUE];
  logic [NUM_ISSUE-1:0] needTag;
  logic accept;

  AReg comRd   [NUM_COMMIT];
  Tag  comTag  [NUM_COMMIT];
  Tag  comPrev [NUM_COMMIT];
  logic [NUM_COMMIT-1:0] comWr;
  logic [NUM_COMMIT-1:0] repWr;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ISSUE; gi++) begin : gRen
      assign renRd[gi]   = bus.IN_renRd[gi];
      assign renRs1[gi]  = bus.IN_renRs1[gi];
      assign renRs2[gi]  = bus.IN_renRs2[gi];
      assign needTag[gi] = bus.IN_renValid[gi] && (bus.IN_renRd[gi] != '0);
      assign renDst[gi]  = (bus.IN_renRd[gi] != '0) ? {1'b0, bus.IN_freeTags[gi]} : ZERO_TAG;
    end

    for (gi = 0; gi < NUM_COMMIT; gi++) begin : gCom
      logic younger;
      assign comRd[gi]  = bus.IN_commitRd[gi];
      assign comTag[gi] = bus.IN_commitTagDst[gi];
      // Real commits only outside the flush window; during flush the ports carry replays.
      assign comWr[gi]  = !bus.IN_mispredFlush && bus.IN_commitValid[gi] && (bus.IN_commitRd[gi] != '0);
      assign repWr[gi]  = bus.IN_mispredFlush && !bus.IN_mispr && bus.IN_commitValid[gi] &&
                          (bus.IN_commitRd[gi] != '0);
      // A younger commit to the same rd in this group supersedes this slot's newest claim.
      always_comb begin
        younger = 1'b0;
        for (int k = gi + 1; k < NUM_COMMIT; k++) begin
          if (comWr[k] && (comRd[k] == comRd[gi])) younger = 1'b1;
        end
      end
      assign bus.OUT_commitNewest[gi]   = comWr[gi] && !younger && (specMap[comRd[gi]] == comTag[gi]);
      assign bus.OUT_commitPrevTags[gi] = comWr[gi] ? comPrev[gi] : ZERO_TAG;
    end
  endgenerate

  // Whole group or nothing: any needing slot without an offered tag blocks all slots.
  assign accept = !bus.IN_mispr && !bus.IN_mispredFlush && (&(~needTag | bus.IN_freeTagsValid));
  assign bus.OUT_stall      = (|bus.IN_renValid) && !accept;
  assign bus.OUT_issueValid = accept ? needTag : '0;

  map_bypass_lookup #(.N(NUM_ISSUE)) uSrc1 (
    .baseMap(specMap), .qReg(renRs1), .wrEn(needTag), .wrReg(renRd), .wrTag(renDst), .result(src1)
  );
  map_bypass_lookup #(.N(NUM_ISSUE)) uSrc2 (
    .baseMap(specMap), .qReg(renRs2), .wrEn(needTag), .wrReg(renRd), .wrTag(renDst), .result(src2)
  );
  map_bypass_lookup #(.N(NUM_ISSUE)) uPrev (
    .baseMap(specMap), .qReg(renRd), .wrEn(needTag), .wrReg(renRd), .wrTag(renDst), .result(prev)
  );
  map_bypass_lookup #(.N(NUM_COMMIT)) uComPrev (
    .baseMap(comMap), .qReg(comRd), .wrEn(comWr), .wrReg(comRd), .wrTag(comTag), .result(comPrev)
  );

  // Next maps: later slots win; mispredict copies the post-commit committed map.
  always_comb begin
    comMapNext = comMap;
    for (int i = 0; i < NUM_COMMIT; i++) begin
      if (comWr[i]) comMapNext[comRd[i]] = comTag[i];
    end
    specMapNext = specMap;
    if (bus.IN_mispr) begin
      specMapNext = comMapNext;
    end else begin
      for (int i = 0; i < NUM_COMMIT; i++) begin
        if (repWr[i]) specMapNext[comRd[i]] = comTag[i];
      end
      if (accept) begin
        for (int i = 0; i < NUM_ISSUE; i++) begin
          if (needTag[i]) specMapNext[renRd[i]] = renDst[i];
        end
      end
    end
  end

  // Map state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_AREGS; r++) begin
        specMap[r] <= ZERO_TAG;
        comMap[r]  <= ZERO_TAG;
      end
    end else begin
      specMap <= specMapNext;
      comMap  <= comMapNext;
    end
  end

  // Rename results, one cycle after the request; dropped groups produce no valids.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.OUT_renValid <= '0;
      for (int i = 0; i < NUM_ISSUE; i++) begin
        bus.OUT_srcTag1[i] <= '0;
        bus.OUT_srcTag2[i] <= '0;
        bus.OUT_dstTag[i]  <= '0;
        bus.OUT_prevTag[i] <= '0;
      end
    end else begin
      bus.OUT_renValid <= accept ? bus.IN_renValid : '0;
      for (int i = 0; i < NUM_ISSUE; i++) begin
        bus.OUT_srcTag1[i] <= src1[i];
        bus.OUT_srcTag2[i] <= src2[i];
        bus.OUT_dstTag[i]  <= renDst[i];
        bus.OUT_prevTag[i] <= prev[i];
      end
    end
  end

endmodule

// File: tb/tb_rename_map_table.sv
// Self-checking bench: sequential map model plus hand-computed literal expectations.
module tb_rename_map_table;
  import rename_map_table_pkg::*;

  typedef logic [NUM_AREGS-1:0][TAG_W-1:0]  MapP;
  typedef logic [NUM_ISSUE-1:0][TAG_W-1:0]  TagVecI;
  typedef logic [NUM_COMMIT-1:0][TAG_W-1:0] TagVecC;
  typedef struct packed { int sel; int slot; logic [31:0] val; } Lit;

  localparam logic [31:0] Z = 32'(ZERO_TAG);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rename_map_table_if bus ();
  rename_map_table dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;
  logic started = 1'b0;

  // Model state
  MapP mSpec, mCom;
  logic [NUM_ISSUE-1:0] eRenValid;
  TagVecI eSrc1, eSrc2, eDst, ePrev;

  Lit litQ[$];
  int litRd = 0;

  // ---------------- model functions (sequential, slot by slot) ----------------
  function automatic logic [NUM_ISSUE-1:0] mNeed();
    logic [NUM_ISSUE-1:0] n;
    for (int i = 0; i < NUM_ISSUE; i++) n[i] = bus.IN_renValid[i] && (bus.IN_renRd[i] != 0);
    return n;
  endfunction

  function automatic logic mAccept();
    logic [NUM_ISSUE-1:0] n;
    logic ok;
    n = mNeed();
    ok = !bus.IN_mispr && !bus.IN_mispredFlush;
    for (int i = 0; i < NUM_ISSUE; i++) if (n[i] && !bus.IN_freeTagsValid[i]) ok = 1'b0;
    return ok;
  endfunction

  // which: 0 src1, 1 src2, 2 dst, 3 prev, 4 returns nothing useful (map via mRenMap)
  function automatic TagVecI mRen(input int which);
    MapP m;
    TagVecI r;
    Tag s1, s2, d, p;
    m = mSpec;
    for (int i = 0; i < NUM_ISSUE; i++) begin
      s1 = (bus.IN_renRs1[i] == 0) ? ZERO_TAG : m[bus.IN_renRs1[i]];
      s2 = (bus.IN_renRs2[i] == 0) ? ZERO_TAG : m[bus.IN_renRs2[i]];
      p  = (bus.IN_renRd[i] == 0)  ? ZERO_TAG : m[bus.IN_renRd[i]];
      d  = (bus.IN_renRd[i] == 0)  ? ZERO_TAG : {1'b0, bus.IN_freeTags[i]};
      case (which)
        0: r[i] = s1;
        1: r[i] = s2;
        2: r[i] = d;
        default: r[i] = p;
      endcase
      if (bus.IN_renValid[i] && bus.IN_renRd[i] != 0) m[bus.IN_renRd[i]] = d;
    end
    return r;
  endfunction

  function automatic MapP mRenMap();
    MapP m;
    m = mSpec;
    for (int i = 0; i < NUM_ISSUE; i++)
      if (bus.IN_renValid[i] && bus.IN_renRd[i] != 0) m[bus.IN_renRd[i]] = {1'b0, bus.IN_freeTags[i]};
    return m;
  endfunction

  function automatic MapP mComAfter();
    MapP m;
    m = mCom;
    if (!bus.IN_mispredFlush)
      for (int i = 0; i < NUM_COMMIT; i++)
        if (bus.IN_commitValid[i] && bus.IN_commitRd[i] != 0) m[bus.IN_commitRd[i]] = bus.IN_commitTagDst[i];
    return m;
  endfunction

  function automatic MapP mReplay();
    MapP m;
    m = mSpec;
    for (int i = 0; i < NUM_COMMIT; i++)
      if (bus.IN_commitValid[i] && bus.IN_commitRd[i] != 0) m[bus.IN_commitRd[i]] = bus.IN_commitTagDst[i];
    return m;
  endfunction

  function automatic TagVecC mComPrev();
    MapP m;
    TagVecC r;
    m = mCom;
    for (int i = 0; i < NUM_COMMIT; i++) begin
      if (bus.IN_mispredFlush || !bus.IN_commitValid[i] || bus.IN_commitRd[i] == 0) begin
        r[i] = ZERO_TAG;
      end else begin
        r[i] = m[bus.IN_commitRd[i]];
        m[bus.IN_commitRd[i]] = bus.IN_commitTagDst[i];
      end
    end
    return r;
  endfunction

  function automatic logic [NUM_COMMIT-1:0] mNewest();
    logic [NUM_COMMIT-1:0] r;
    for (int i = 0; i < NUM_COMMIT; i++) begin
      r[i] = !bus.IN_mispredFlush && bus.IN_commitValid[i] && bus.IN_commitRd[i] != 0 &&
             mSpec[bus.IN_commitRd[i]] == bus.IN_commitTagDst[i];
      for (int k = i + 1; k < NUM_COMMIT; k++)
        if (bus.IN_commitValid[k] && bus.IN_commitRd[k] == bus.IN_commitRd[i]) r[i] = 1'b0;
    end
    return r;
  endfunction

  // Model state update at each active edge.
  always @(posedge clk) begin
    MapP c;
    MapP s;
    if (rst) begin
      mSpec <= {NUM_AREGS{ZERO_TAG}};
      mCom  <= {NUM_AREGS{ZERO_TAG}};
      eRenValid <= '0;
      eSrc1 <= '0; eSrc2 <= '0; eDst <= '0; ePrev <= '0;
      started <= 1'b1;
    end else begin
      c = mComAfter();
      if (bus.IN_mispr) s = c;
      else if (bus.IN_mispredFlush) s = mReplay();
      else if (mAccept()) s = mRenMap();
      else s = mSpec;
      mSpec <= s;
      mCom  <= c;
      eRenValid <= mAccept() ? bus.IN_renValid : '0;
      eSrc1 <= mRen(0); eSrc2 <= mRen(1); eDst <= mRen(2); ePrev <= mRen(3);
    end
  end

  // ---------------- compare process ----------------
  task automatic chk(input string name, input int slot, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s slot=%0d got=%h want=%h t=%0t", name, slot, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick(input int sel, input int slot);
    case (sel)
      0: return 32'(bus.OUT_issueValid);
      1: return 32'(bus.OUT_stall);
      2: return 32'(bus.OUT_renValid);
      3: return 32'(bus.OUT_srcTag1[slot]);
      4: return 32'(bus.OUT_srcTag2[slot]);
      5: return 32'(bus.OUT_dstTag[slot]);
      6: return 32'(bus.OUT_prevTag[slot]);
      7: return 32'(bus.OUT_commitPrevTags[slot]);
      default: return 32'(bus.OUT_commitNewest);
    endcase
  endfunction

  function automatic string litName(input int sel);
    case (sel)
      0: return "lit_issueValid";
      1: return "lit_stall";
      2: return "lit_renValid";
      3: return "lit_srcTag1";
      4: return "lit_srcTag2";
      5: return "lit_dstTag";
      6: return "lit_prevTag";
      7: return "lit_commitPrev";
      default: return "lit_commitNewest";
    endcase
  endfunction

  always @(negedge clk) begin
    TagVecC cp;
    Lit l;
    if (started) begin
      cp = mComPrev();
      chk("issueValid", 0, 32'(bus.OUT_issueValid), 32'(mAccept() ? mNeed() : '0));
      chk("stall", 0, 32'(bus.OUT_stall), 32'((|bus.IN_renValid) && !mAccept()));
      for (int i = 0; i < NUM_COMMIT; i++)
        chk("commitPrev", i, 32'(bus.OUT_commitPrevTags[i]), 32'(cp[i]));
      chk("commitNewest", 0, 32'(bus.OUT_commitNewest), 32'(mNewest()));
      chk("renValid", 0, 32'(bus.OUT_renValid), 32'(eRenValid));
      for (int i = 0; i < NUM_ISSUE; i++) begin
        if (eRenValid[i]) begin
          chk("srcTag1", i, 32'(bus.OUT_srcTag1[i]), 32'(eSrc1[i]));
          chk("srcTag2", i, 32'(bus.OUT_srcTag2[i]), 32'(eSrc2[i]));
          chk("dstTag",  i, 32'(bus.OUT_dstTag[i]),  32'(eDst[i]));
          chk("prevTag", i, 32'(bus.OUT_prevTag[i]), 32'(ePrev[i]));
        end
      end
      while (litRd < litQ.size()) begin
        l = litQ[litRd];
        litRd++;
        chk(litName(l.sel), l.slot, pick(l.sel, l.slot), l.val);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    bus.IN_mispr = 1'b0;
    bus.IN_mispredFlush = 1'b0;
    bus.IN_renValid = '0;
    bus.IN_freeTagsValid = '0;
    bus.IN_commitValid = '0;
    for (int i = 0; i < NUM_ISSUE; i++) begin
      bus.IN_renRd[i] = '0; bus.IN_renRs1[i] = '0; bus.IN_renRs2[i] = '0; bus.IN_freeTags[i] = '0;
    end
    for (int i = 0; i < NUM_COMMIT; i++) begin
      bus.IN_commitRd[i] = '0; bus.IN_commitTagDst[i] = '0;
    end
  endtask

  task automatic ren(input int s, input int rd, input int rs1, input int rs2, input int tag);
    bus.IN_renValid[s] = 1'b1;
    bus.IN_renRd[s] = AReg'(rd);
    bus.IN_renRs1[s] = AReg'(rs1);
    bus.IN_renRs2[s] = AReg'(rs2);
    bus.IN_freeTags[s] = RFTag'(tag);
    bus.IN_freeTagsValid[s] = 1'b1;
  endtask

  task automatic com(input int s, input int rd, input int tag);
    bus.IN_commitValid[s] = 1'b1;
    bus.IN_commitRd[s] = AReg'(rd);
    bus.IN_commitTagDst[s] = Tag'(tag);
  endtask

  task automatic lit(input int sel, input int slot, input logic [31:0] val);
    Lit l;
    l.sel = sel; l.slot = slot; l.val = val;
    litQ.push_back(l);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    cyc(); cyc();
    // Reset values of registered outputs
    rst = 1'b0;
    idle(); lit(2, 0, 0); lit(3, 0, 0); lit(5, 0, 0); cyc();
    // Single rename x5 <- x5, tag 3
    idle(); ren(0, 5, 5, 0, 3); lit(0, 0, 32'b0001); lit(1, 0, 0); cyc();
    idle(); lit(2, 0, 32'b0001); lit(3, 0, Z); lit(5, 0, 3); lit(6, 0, Z); cyc();
    // Intra-group bypass on x1
    idle(); ren(0, 1, 0, 0, 4); ren(1, 1, 1, 0, 9); lit(0, 0, 32'b0011); cyc();
    idle(); ren(0, 0, 1, 0, 0);
    lit(2, 0, 32'b0011); lit(3, 1, 4); lit(6, 1, 4); lit(5, 1, 9); lit(0, 0, 0); lit(1, 0, 0); cyc();
    // x1 reads 9; slot2 missing its tag stalls the group
    idle(); ren(0, 2, 0, 0, 6); ren(2, 6, 0, 0, 8); bus.IN_freeTagsValid[2] = 1'b0;
    lit(3, 0, 9); lit(1, 0, 1); lit(0, 0, 0); cyc();
    // No result from stalled group; commit x1 tag4 then tag9
    idle(); com(0, 1, 4); com(1, 1, 9);
    lit(2, 0, 0); lit(7, 0, Z); lit(7, 1, 4); lit(8, 0, 32'b0010); cyc();
    // specMap[x2]=5, then rename x2->7 while committing x2=5 and x1=12
    idle(); ren(0, 2, 0, 0, 5); cyc();
    idle(); ren(0, 2, 0, 0, 7); com(0, 2, 5); com(1, 1, 12);
    lit(8, 0, 32'b0001); lit(7, 0, Z); lit(7, 1, 9); lit(0, 0, 32'b0001); cyc();
    // Mispredict: rename dropped
    idle(); bus.IN_mispr = 1'b1; ren(0, 3, 0, 0, 10); lit(1, 0, 1); lit(0, 0, 0); cyc();
    idle(); ren(0, 0, 2, 1, 0); lit(2, 0, 0); cyc();
    idle(); lit(2, 0, 32'b0001); lit(3, 0, 5); lit(4, 0, 12); cyc();
    // Flush replay x3 tag 11
    idle(); bus.IN_mispredFlush = 1'b1; com(0, 3, 11); ren(0, 4, 0, 0, 1);
    lit(8, 0, 0); lit(7, 0, Z); lit(1, 0, 1); cyc();
    idle(); ren(0, 0, 3, 0, 0); com(0, 3, 11); lit(7, 0, Z); lit(8, 0, 32'b0001); cyc();
    idle(); lit(3, 0, 11); cyc();
    // Four-slot chain, youngest writer to x7 wins
    idle(); ren(0, 7, 0, 0, 20); ren(1, 7, 7, 7, 21); ren(2, 8, 7, 0, 22); ren(3, 7, 8, 7, 23); cyc();
    idle(); ren(0, 0, 7, 8, 0); lit(3, 3, 22); lit(4, 3, 21); lit(6, 3, 21); lit(6, 1, 20); cyc();
    idle(); lit(3, 0, 23); lit(4, 0, 22); cyc();
    // Mispredict with flush: replay ignored, spec restored from committed map
    idle(); bus.IN_mispr = 1'b1; bus.IN_mispredFlush = 1'b1; com(0, 4, 13); lit(8, 0, 0); lit(7, 0, Z); cyc();
    idle(); ren(0, 0, 4, 7, 0); com(0, 0, 5); com(2, 6, 30); lit(7, 0, Z); lit(8, 0, 0); cyc();
    idle(); lit(3, 0, Z); lit(4, 0, Z); cyc();
    // Reset mid-operation
    idle(); ren(0, 9, 0, 0, 15); cyc();
    rst = 1'b1; idle(); ren(0, 10, 0, 0, 16); cyc();
    rst = 1'b0; idle(); ren(0, 0, 9, 1, 0); lit(2, 0, 0); cyc();
    idle(); lit(2, 0, 32'b0001); lit(3, 0, Z); lit(4, 0, Z); cyc();
    idle(); cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
